// File: rtl/ca_pkg.sv
// Shared types and constants for the multi-generation CA row generator.
package ca_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      STREAM,
      DRAIN,
      DONE
   } ca_state_e;

   localparam logic [7:0] RULE_30  = 8'd30;
   localparam logic [7:0] RULE_90  = 8'd90;
   localparam logic [7:0] RULE_110 = 8'd110;

endpackage

// File: rtl/ca_row_window.sv
// L/C/R neighbourhood capture for streamed row words, one cycle of storage per word.
// CA_GEN_TORUS_EN selects a wrapping row; otherwise the row edges see zero neighbours.
module ca_row_window #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap,
   input  logic             first,
   input  logic             last,
   input  logic [WIDTH-1:0] rdata,
   output logic             left,
   output logic [WIDTH-1:0] cells,
   output logic             right
);

   logic             l_q, l_d;
   logic [WIDTH-1:0] c_q, c_d;

   always_comb begin
      l_d = l_q;
      c_d = c_q;
      if (cap) begin
         c_d = rdata;
`ifdef CA_GEN_TORUS_EN
         l_d = c_q[WIDTH-1];
`else
         l_d = first ? 1'b0 : c_q[WIDTH-1];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_q <= 1'b0;
         c_q <= '0;
      end else begin
         l_q <= l_d;
         c_q <= c_d;
      end
   end

   // The right neighbour is taken live from the RAM so the last word of a row can be
   // written in the same cycle the wrap read returns.
`ifdef CA_GEN_TORUS_EN
   logic unused_edge;
   assign unused_edge = first ^ last;
   assign right       = rdata[0];
`else
   assign right = last ? 1'b0 : rdata[0];
`endif

   assign left  = l_q;
   assign cells = c_q;

endmodule

// File: rtl/comb_ca.sv
// Combinational elementary CA step over one word; zero latency, no flow control.
// Neighbour pattern is {left, centre, right}, where left is the next-lower cell index.
module comb_ca #(
   parameter int WIDTH = 16
) (
   input  logic [7:0]       rule,
   input  logic             left,
   input  logic [WIDTH-1:0] cells,
   input  logic             right,
   output logic [WIDTH-1:0] next
);

   logic [WIDTH+1:0] ext;

   assign ext = {right, cells, left};

   for (genvar b = 0; b < WIDTH; b++) begin : g_cell
      assign next[b] = rule[{ext[b], ext[b+1], ext[b+2]}];
   end

endmodule

// File: rtl/ca_gen_multi.sv
// Runs gens CA generations over a RAM row, ping-ponging src/dst; generation period WORDS+3 cycles.
// No backpressure: RAM is fixed 1-cycle latency. Edge mode set by CA_GEN_TORUS_EN.
module ca_gen_multi
   import ca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int WORDS = 80,
   parameter int AW    = 8,
   parameter int GW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       rule,
   input  logic [AW-1:0]    src_base,
   input  logic [AW-1:0]    dst_base,
   input  logic [GW-1:0]    gens,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    res_base,
   output logic             read,
   output logic [AW-1:0]    raddr,
   input  logic [WIDTH-1:0] rdata,
   output logic             write,
   output logic [AW-1:0]    waddr,
   output logic [WIDTH-1:0] wdata
);

   localparam int CW = $clog2(WORDS + 3);

   ca_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gen_left_q, gen_left_d;
   logic [7:0]    rule_q, rule_d;
   logic [AW-1:0] src_q, src_d, dst_q, dst_d;
   logic          read_q, read_d, write_q, write_d;
   logic          busy_q, busy_d, done_q, done_d, rvld_q, rvld_d;
   logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d, res_base_q, res_base_d;
   logic [AW-1:0] rd_idx;

   logic             win_first, win_last, win_left, win_right;
   logic [WIDTH-1:0] win_cells, nxt_cells;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gen_left_d = gen_left_q;
      rule_d     = rule_q;
      src_d      = src_q;
      dst_d      = dst_q;
      raddr_d    = raddr_q;
      waddr_d    = waddr_q;
      res_base_d = res_base_q;
      rvld_d     = read_q;
      rd_idx     = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               rule_d     = rule;
               src_d      = src_base;
               dst_d      = dst_base;
               gen_left_d = gens;
               cnt_d      = '0;
               state_d    = (gens == '0) ? DONE : PRIME;
            end
         end
         PRIME: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(1)) state_d = STREAM;
         end
         STREAM: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WORDS + 1)) state_d = DRAIN;
         end
         DRAIN: begin
            src_d      = dst_q;
            dst_d      = src_q;
            gen_left_d = gen_left_q - 1'b1;
            cnt_d      = '0;
            state_d    = (gen_left_q == GW'(1)) ? DONE : PRIME;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so every strobe leaves a flop.
      // Read order per generation: last word, words 0..WORDS-1, then word 0 again.
      read_d = (state_d == PRIME) || (state_d == STREAM);
      if (cnt_d == '0)                 rd_idx = AW'(WORDS - 1);
      else if (cnt_d == CW'(WORDS + 1)) rd_idx = '0;
      else                             rd_idx = AW'(cnt_d - 1'b1);
      if (read_d) raddr_d = src_d + rd_idx;

      write_d = ((state_d == STREAM) || (state_d == DRAIN)) && (cnt_d >= CW'(3));
      if (write_d) waddr_d = dst_d + AW'(cnt_d - CW'(3));

      busy_d = (state_d == PRIME) || (state_d == STREAM) || (state_d == DRAIN);
      done_d = (state_d == DONE);
      if (done_d) res_base_d = src_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gen_left_q <= '0;
         rule_q     <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rvld_q     <= 1'b0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         res_base_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gen_left_q <= gen_left_d;
         rule_q     <= rule_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         read_q     <= read_d;
         write_q    <= write_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rvld_q     <= rvld_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         res_base_q <= res_base_d;
      end
   end

   // Word 0 of the row lands in the window at cycle 2; the wrap read returns during DRAIN.
   assign win_first = (state_q == STREAM) && (cnt_q == CW'(2));
   assign win_last  = (state_q == DRAIN);

   ca_row_window #(.WIDTH(WIDTH)) u_win (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (rvld_q),
      .first (win_first),
      .last  (win_last),
      .rdata (rdata),
      .left  (win_left),
      .cells (win_cells),
      .right (win_right)
   );

   comb_ca #(.WIDTH(WIDTH)) u_ca (
      .rule  (rule_q),
      .left  (win_left),
      .cells (win_cells),
      .right (win_right),
      .next  (nxt_cells)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign res_base = res_base_q;
   assign read     = read_q;
   assign raddr    = raddr_q;
   assign write    = write_q;
   assign waddr    = waddr_q;
   assign wdata    = write_q ? nxt_cells : '0;

endmodule

// File: tb/tb_ca_gen_multi.sv
// Scoreboard bench for ca_gen_multi with WIDTH=16, WORDS=4 and a behavioural 1-cycle RAM.
module tb_ca_gen_multi;
   import ca_pkg::*;

   localparam int WIDTH = 16;
   localparam int WORDS = 4;
   localparam int AW    = 8;
   localparam int GW    = 8;
   localparam int P     = WORDS + 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rule_i = '0;
   logic [7:0]  src_i = '0, dst_i = '0;
   logic [7:0]  gens_i = '0;
   logic        busy, done, read, write;
   logic [7:0]  res_base, raddr, waddr;
   logic [15:0] rdata = '0, wdata;

   logic [15:0] mem [256];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [15:0] pl_dat = '0;

   typedef struct {
      int          cyc;
      logic [7:0]  a;
      logic [15:0] d;
   } ev_t;

   ev_t rq[$], wq[$], dq[$];
   int  total = 0, bad = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;
   int  busy_lo = 0, busy_hi = -1;

   ca_gen_multi #(.WIDTH(WIDTH), .WORDS(WORDS), .AW(AW), .GW(GW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rule     (rule_i),
      .src_base (src_i),
      .dst_base (dst_i),
      .gens     (gens_i),
      .busy     (busy),
      .done     (done),
      .res_base (res_base),
      .read     (read),
      .raddr    (raddr),
      .rdata    (rdata),
      .write    (write),
      .waddr    (waddr),
      .wdata    (wdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_en) mem[pl_addr] <= pl_dat;
      if (write) mem[waddr] <= wdata;
      rdata <= read ? mem[raddr] : 16'hA5C3;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic flag_bad(input string nm, input logic [63:0] act);
      total++;
      bad++;
      $display("FAIL %s: actual=%h required=none", nm, act);
   endtask

   // Monitor: pops expected strobes in order and compares cycle, address and data.
   always @(negedge clk) begin
      ev_t e;
      if (mon_en && rst_n) begin
         if (read) begin
            if (rq.size() == 0) flag_bad("unexpected_read", {cyc, 24'h0, raddr});
            else begin
               e = rq.pop_front();
               check("read", {cyc, 24'h0, raddr}, {e.cyc, 24'h0, e.a});
            end
         end
         if (write) begin
            if (wq.size() == 0) flag_bad("unexpected_write", {cyc, 8'h0, waddr, wdata});
            else begin
               e = wq.pop_front();
               check("write", {cyc, 8'h0, waddr, wdata}, {e.cyc, 8'h0, e.a, e.d});
            end
         end
         if (done) begin
            if (dq.size() == 0) flag_bad("unexpected_done", {cyc, 24'h0, res_base});
            else begin
               e = dq.pop_front();
               check("done", {cyc, 24'h0, res_base}, {e.cyc, 24'h0, e.a});
            end
         end
         check("busy", {63'h0, busy}, {63'h0, (cyc >= busy_lo) && (cyc <= busy_hi)});
      end
   end

   function automatic logic [63:0] ca_step(input logic [63:0] r, input logic [7:0] rl, input bit tor);
      logic [63:0] n;
      logic        l, c, rr;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         l  = (i == 0)  ? (tor ? r[63] : 1'b0) : r[i-1];
         c  = r[i];
         rr = (i == 63) ? (tor ? r[0] : 1'b0)  : r[i+1];
         n[i] = rl[{l, c, rr}];
      end
      return n;
   endfunction

   task automatic load_row(input logic [7:0] base, input logic [63:0] row);
      for (int w = 0; w < WORDS; w++) begin
         pl_en   = 1'b1;
         pl_addr = base + 8'(w);
         pl_dat  = row[w*16 +: 16];
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
   endtask

   task automatic run(input logic [7:0] rl, input logic [7:0] sb, input logic [7:0] db,
                      input int g, input logic [63:0] row0, input bit poke,
                      output logic [63:0] final_row);
      logic [7:0]  s, d, t8;
      logic [63:0] cur, nxt;
      int          sc, t, idx, n;
      bit          tor;
`ifdef CA_GEN_TORUS_EN
      tor = 1'b1;
`else
      tor = 1'b0;
`endif
      sc  = cyc;
      s   = sb;
      d   = db;
      cur = row0;
      for (int gi = 0; gi < g; gi++) begin
         t   = sc + 1 + gi * P;
         nxt = ca_step(cur, rl, tor);
         for (int i = 0; i < WORDS + 2; i++) begin
            idx = (i == 0) ? WORDS - 1 : (i == WORDS + 1) ? 0 : i - 1;
            rq.push_back('{t + i, s + 8'(idx), 16'h0});
         end
         for (int k = 0; k < WORDS; k++)
            wq.push_back('{t + 3 + k, d + 8'(k), nxt[k*16 +: 16]});
         t8 = s; s = d; d = t8;
         cur = nxt;
      end
      dq.push_back('{sc + g * P + 1, (g % 2 == 1) ? db : sb, 16'h0});
      busy_lo = sc + 1;
      busy_hi = sc + g * P;

      start = 1'b1; rule_i = rl; src_i = sb; dst_i = db; gens_i = 8'(g);
      @(posedge clk); #1;
      start = 1'b0; rule_i = ~rl; src_i = ~sb; dst_i = ~db; gens_i = 8'd5;
      if (poke) begin
         @(posedge clk); #1;
         start = 1'b1; gens_i = 8'd2;
         @(posedge clk); #1;
         start = 1'b0;
      end
      n = 0;
      while ((rq.size() + wq.size() + dq.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (rq.size() + wq.size() + dq.size() != 0) begin
         flag_bad("timeout_pending", 64'(rq.size() + wq.size() + dq.size()));
         rq.delete(); wq.delete(); dq.delete();
      end
      repeat (P + 2) @(posedge clk);
      #1;
      busy_hi   = -1;
      final_row = cur;
   endtask

   task automatic check_row(input string nm, input logic [7:0] base, input logic [63:0] row);
      for (int k = 0; k < WORDS; k++)
         check(nm, {48'h0, mem[base + 8'(k)]}, {48'h0, row[k*16 +: 16]});
   endtask

   task automatic check_idle_outputs(input string nm);
      check(nm, {busy, done, read, write, raddr, waddr, wdata, res_base},
                {4'h0, 8'h0, 8'h0, 16'h0, 8'h0});
   endtask

   initial begin
      logic [63:0] fr;
      logic [63:0] row_t1;
      row_t1 = {16'h0000, 16'h0000, 16'h0100, 16'h0000};

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset_outputs");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("post_reset_idle");
      mon_en = 1'b1;

      // Rule 90 on a single interior bit: writes in cycles 4..7, done in 8.
      load_row(8'h00, row_t1);
      run(RULE_90, 8'h00, 8'h20, 1, row_t1, 1'b0, fr);
      check("t1_word1", {48'h0, mem[8'h21]}, 64'h0280);
      check("t1_word0", {48'h0, mem[8'h20]}, 64'h0000);
      check_row("t1_row", 8'h20, fr);

      // Edge behaviour of bit 0 of word 0.
      load_row(8'h40, {16'h0000, 16'h0000, 16'h0000, 16'h0001});
      run(RULE_90, 8'h40, 8'h50, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 1'b0, fr);
      check("t2_word0", {48'h0, mem[8'h50]}, 64'h0002);
`ifdef CA_GEN_TORUS_EN
      check("t2_word3", {48'h0, mem[8'h53]}, 64'h8000);
`else
      check("t2_word3", {48'h0, mem[8'h53]}, 64'h0000);
`endif

      // Three generations of rule 30; result lands at dst_base.
      load_row(8'h60, row_t1);
      run(RULE_30, 8'h60, 8'h70, 3, row_t1, 1'b0, fr);
      check("t3_word1", {48'h0, mem[8'h71]}, 64'h0F60);
      check_row("t3_row", 8'h70, fr);

      // Zero generations, then a start pulse while busy that must be ignored.
      run(RULE_110, 8'h80, 8'h90, 0, 64'h0, 1'b0, fr);
      run(RULE_90, 8'h00, 8'h30, 1, row_t1, 1'b1, fr);
      check("t4_word1", {48'h0, mem[8'h31]}, 64'h0280);

      // Reset asserted in cycle 5 of generation 0.
      mon_en = 1'b0;
      start = 1'b1; rule_i = RULE_90; src_i = 8'h00; dst_i = 8'hB0; gens_i = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t5_busy_before_reset", {63'h0, busy}, 64'h1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("t5_reset_mid_run");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      run(RULE_90, 8'h00, 8'h28, 1, row_t1, 1'b0, fr);
      check("t5_rerun_word1", {48'h0, mem[8'h29]}, 64'h0280);

      // Source row wrapping the address space; two generations bring the result back to src.
      load_row(8'hFE, {16'h8001, 16'h00F0, 16'h8000, 16'h0003});
      run(RULE_110, 8'hFE, 8'hA0, 2, {16'h8001, 16'h00F0, 16'h8000, 16'h0003}, 1'b0, fr);
      check_row("t6_row", 8'hFE, fr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
